// File: rtl/ps2_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_frame_rx                                                 |
// | Description : PS/2 device-to-host frame receiver. Synchronises and         |
// |               deglitches kbd_clk/kbd_dat, deserialises start/data/parity/  |
// |               stop frames, checks parity and stop bit, and queues good     |
// |               bytes in a first-word fall-through FIFO (valid/ready).       |
// | Options     : define PS2_TIMEOUT_EN to abort partial frames after          |
// |               TIMEOUT_CYC idle clk cycles.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_frame_rx #(
    parameter int DATA_BITS   = 8,      // 5..9, LSB first on the wire
    parameter int PARITY_MODE = 1,      // 0 none, 1 odd, 2 even
    parameter int FIFO_DEPTH  = 4,      // power of 2, >= 2
    parameter int SYNC_STAGES = 2,      // >= 2
    parameter int FILT_LEN    = 4,      // samples needed to flip the filtered clock
    parameter int TIMEOUT_CYC = 50000   // used only with PS2_TIMEOUT_EN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          kbd_clk,
    input  logic                          kbd_dat,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_fw = $clog2(FILT_LEN + 1);
    localparam int c_bw = $clog2(DATA_BITS + 1);

    localparam logic [c_aw:0]   c_depth     = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_fw-1:0] c_filt_last = c_fw'(FILT_LEN - 1);
    localparam logic [c_bw-1:0] c_bit_last  = c_bw'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_CHECK  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and clock deglitch filter
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic [c_fw-1:0]        filt_cnt_q, filt_cnt_d;
    logic                   filt_q, filt_d;
    logic                   filt_prev_q, filt_prev_d;
    logic                   clk_s;
    logic                   dat_s;
    logic                   strobe;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign dat_s  = dat_sync_q[SYNC_STAGES-1];
    // One-cycle strobe on each falling edge of the filtered clock.
    assign strobe = filt_prev_q & ~filt_q;

    // Shift raw pins through the synchronisers; flip the filtered clock only
    // after FILT_LEN consecutive samples disagree with its current level.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], kbd_clk};
        dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], kbd_dat};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        filt_prev_d = filt_q;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == c_filt_last) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Input registers preset high so an idle bus never produces a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            filt_cnt_q  <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Partial-frame timeout
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   tmo_hit;

`ifdef PS2_TIMEOUT_EN
    localparam int              c_tw       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT_CYC - 1);

    logic [c_tw-1:0] tmo_q, tmo_d;

    // Count idle cycles between strobes while a frame is in flight.
    always_comb begin
        tmo_d   = tmo_q + 1'b1;
        tmo_hit = 1'b0;
        if (state_q == S_IDLE || state_q == S_CHECK || strobe) begin
            tmo_d = '0;
        end else if (tmo_q == c_tmo_last) begin
            tmo_hit = 1'b1;
            tmo_d   = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYC;
    assign tmo_hit        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [c_bw-1:0]      bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovf_q, ovf_d;
    logic                 parity_ok;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;

    // Received parity bit against the data word.
    always_comb begin
        parity_ok = 1'b1;
        if (PARITY_MODE == 1) begin
            parity_ok = (^shift_q) ^ par_q;
        end else if (PARITY_MODE == 2) begin
            parity_ok = ~((^shift_q) ^ par_q);
        end
    end

    // Next-state logic: every state but CHECK advances only on a strobe.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        ovf_d    = 1'b0;
        push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (strobe && !dat_s) begin
                    state_d  = S_DATA;
                    bitcnt_d = '0;
                end
            end
            S_DATA: begin
                if (strobe) begin
                    shift_d  = {dat_s, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == c_bit_last) begin
                        state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (strobe) begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (strobe) begin
                    if (dat_s) begin
                        state_d = S_CHECK;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (!parity_ok) begin
                    perr_d = 1'b1;
                end else if (fifo_full && !pop) begin
                    ovf_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
        end
    end

    // FSM state, datapath and registered error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [c_aw-1:0]      wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]      rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]        count_q, count_d;

    assign dout_valid = (count_q != '0);
    assign fifo_full  = (count_q == c_depth);
    assign pop        = dout_valid & dout_ready;
    assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;

    // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ps2_frame_rx                                              |
// | Description : Self-checking bench for ps2_frame_rx with a byte scoreboard. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ps2_frame_rx;

    localparam int DB  = 8;
    localparam int DEP = 4;
    localparam int FL  = 4;
    localparam int TMO = 2000;

    logic             clk = 1'b0;
    logic             reset;
    logic             kbd_clk;
    logic             kbd_dat;
    logic [DB-1:0]    dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [2:0]       fifo_count;
    logic             parity_err;
    logic             frame_err;
    logic             overflow;

    ps2_frame_rx #(
        .DATA_BITS   (DB),
        .PARITY_MODE (1),
        .FIFO_DEPTH  (DEP),
        .SYNC_STAGES (2),
        .FILT_LEN    (FL),
        .TIMEOUT_CYC (TMO)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .kbd_clk    (kbd_clk),
        .kbd_dat    (kbd_dat),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [DB-1:0] exp_q [$];
    int            perr_cnt = 0;
    int            ferr_cnt = 0;
    int            ovf_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Flag pulse counters (cycles high) and scoreboard compare on each pop.
    always @(negedge clk) begin
        if (!reset) begin
            if (parity_err) perr_cnt++;
            if (frame_err)  ferr_cnt++;
            if (overflow)   ovf_cnt++;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    check("pop_data", dout, exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        kbd_dat = b;
        cyc(10);
        kbd_clk = 1'b0;
        cyc(20);
        kbd_clk = 1'b1;
        cyc(10);
        if (glitch) begin
            kbd_clk = 1'b0;
            cyc(FL - 1);
            kbd_clk = 1'b1;
            cyc(10);
        end
    endtask

    // Drive a full odd-parity frame; push the byte if it should be queued.
    task automatic send_frame(input logic [DB-1:0] d, input logic par_flip,
                              input logic stop, input bit expect_push, input int glitch_bit);
        if (expect_push) exp_q.push_back(d);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < DB; i++) ps2_bit(d[i], glitch_bit == i);
        ps2_bit((~^d) ^ par_flip, 1'b0);
        ps2_bit(stop, 1'b0);
        kbd_dat = 1'b1;
        cyc(30);
    endtask

    task automatic drain();
        int n;
        n = 0;
        dout_ready = 1'b1;
        cyc(1);
        while (dout_valid && n < 50) begin
            cyc(1);
            n++;
        end
        dout_ready = 1'b0;
        cyc(2);
        check("drain_empty", fifo_count, 0);
    endtask

    int p0, f0, o0;
    logic [DB-1:0] rb;

    initial begin
        reset      = 1'b1;
        kbd_clk    = 1'b1;
        kbd_dat    = 1'b1;
        dout_ready = 1'b0;
        cyc(5);
        reset = 1'b0;
        cyc(3);

        // Reset state
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_flags", {parity_err, frame_err, overflow}, 0);

        // 1: good frame 0x1C
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, -1);
        check("t1_dout", dout, 8'h1C);
        check("t1_valid", dout_valid, 1);
        check("t1_count", fifo_count, 1);
        check("t1_flags", perr_cnt + ferr_cnt + ovf_cnt, 0);
        drain();

        // 2: bad parity
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, -1);
        check("t2_perr", perr_cnt, 1);
        check("t2_count", fifo_count, 0);

        // 3: bad stop, then good 0xF0
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
        check("t3_ferr", ferr_cnt, 1);
        check("t3_count", fifo_count, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b1, -1);
        check("t3_dout", dout, 8'hF0);
        check("t3_perr_same", perr_cnt, 1);
        drain();

        // 4: fill and overflow
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, i <= DEP, -1);
        check("t4_count", fifo_count, DEP);
        check("t4_ovf", ovf_cnt, 1);
        check("t4_head", dout, 8'h01);
        drain();

        // 5: short clock glitch inside frame 0xA3
        send_frame(8'hA3, 1'b0, 1'b1, 1'b1, 3);
        check("t5_count", fifo_count, 1);
        check("t5_dout", dout, 8'hA3);
        check("t5_flags", perr_cnt * 100 + ferr_cnt * 10 + ovf_cnt, 111);
        drain();

        // Back-to-back random bytes with consumer always ready
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, 1'b0, 1'b1, 1'b1, -1);
        end
        dout_ready = 1'b0;
        cyc(3);
        check("b2b_count", fifo_count, 0);

        // 6: truncated frame (start + 4 data bits)
        f0 = ferr_cnt;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
        kbd_dat = 1'b1;
        cyc(TMO + 300);
`ifdef PS2_TIMEOUT_EN
        check("t6_tmo_ferr", ferr_cnt, f0 + 1);
`else
        check("t6_no_ferr", ferr_cnt, f0);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(3);
        check("t6_rst_valid", dout_valid, 0);
`endif
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, -1);
        check("t6_dout", dout, 8'h5A);
        check("t6_count", fifo_count, 1);
        drain();

        p0 = perr_cnt;
        o0 = ovf_cnt;
        check("end_perr", p0, 1);
        check("end_ovf", o0, 1);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
